gm_inst_decode_pipe: RTL and testbench

//  Multi-lane pipelined successor of the single-instruction combinational class decoder in the GMCU front end.
//  - Accepts a bundle of LANES instruction words per beat.
//  - Decodes each word into an instClassType (gmcupkg) with every field defaulted to '0, then overridden per opcode.
//  - Returns the bundle through a valid/ready pipeline with per-lane illegal flags and a saturating illegal counter.
//  - Sits between the fetch-bundle buffer and the issue stage.

---
 rtl/gm_inst_decode_pipe_pkg.sv | 67 ++++++
 rtl/gm_inst_decode_pipe_skid.sv | 37 +++
 rtl/gm_inst_decode_pipe.sv | 144 ++++++++++++++
 tb/tb_gm_inst_decode_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gm_inst_decode_pipe_pkg.sv
// Shared GMCU front-end types: opcodes, functional-unit codes, the decoded
// instruction class, and the per-lane class decoder.
package gmcupkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
    localparam logic [OP_W-1:0] OP_ADD   = 6'h01;
    localparam logic [OP_W-1:0] OP_LDBIO = 6'h21;
    localparam logic [OP_W-1:0] OP_STBIO = 6'h22;

    typedef enum logic [2:0] {
        IFUNC_NONE = 3'd0,
        IFUNC_ADD  = 3'd1,
        IFUNC_BOOL = 3'd2
    } iFuncType;

    typedef struct packed {
        logic bool;
    } subType;

    typedef struct packed {
        logic bool;
    } sub3Type;

    typedef struct packed {
        sub3Type sub3;
    } sub2Type;

    typedef struct packed {
        logic     isBool;
        iFuncType iFunc;
        subType   sub;
        sub2Type  sub2;
    } instClassType;

    typedef struct packed {
        instClassType cls;
        logic         illegal;
    } decode_res_t;

    // A disabled lane is never illegal, whatever its opcode bits hold.
    function automatic decode_res_t decode_inst(input logic [OP_W-1:0] opcode,
                                                input logic            lane_en);
        decode_res_t res;
        res = '0;
        if (lane_en) begin
            case (opcode)
                OP_NOP: ;
                OP_ADD: res.cls.iFunc = IFUNC_ADD;
                OP_LDBIO: begin
                    res.cls.isBool   = 1'b1;
                    res.cls.iFunc    = IFUNC_BOOL;
                    res.cls.sub.bool = 1'b1;
                end
                OP_STBIO: begin
                    res.cls.isBool         = 1'b1;
                    res.cls.iFunc          = IFUNC_BOOL;
                    res.cls.sub2.sub3.bool = 1'b1;
                end
                default: res.illegal = 1'b1;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/gm_inst_decode_pipe_skid.sv
// One-entry bypassing skid register: passes data straight through while empty,
// captures one beat when the consumer stalls, and exposes a registered ready.
module gm_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             full_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (full_reg) begin
            if (out_ready) begin
                full_reg <= 1'b0;
            end
        end else if (in_valid && !out_ready) begin
            full_reg <= 1'b1;
            data_reg <= in_data;
        end
    end

    assign in_ready  = ~full_reg;
    assign out_valid = full_reg | in_valid;
    assign out_data  = full_reg ? data_reg : in_data;

endmodule

// File: rtl/gm_inst_decode_pipe.sv
// Multi-lane two-stage instruction class decoder with valid/ready flow control,
// per-lane illegal flags and a saturating illegal-lane counter.
module gm_inst_decode_pipe
    import gmcupkg::*;
#(
    parameter int LANES  = 2,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16,
    parameter int SKID   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*INST_W-1:0]   in_inst,
    input  logic [LANES-1:0]          in_lane_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output instClassType              out_class [LANES],
    output logic [LANES-1:0]          out_lane_en,
    output logic [LANES-1:0]          out_illegal,
    output logic [CNT_W-1:0]          illegal_cnt
);

    localparam int OPS_W = LANES * OP_W;
    localparam int BW    = OPS_W + LANES;

    // Only the opcode field of each word influences the decode, so only it travels.
    logic [OPS_W-1:0] in_ops;
    logic             up_valid;
    logic             up_ready;
    logic [BW-1:0]    up_data;

    logic             s1_valid_reg;
    logic [OPS_W-1:0] s1_ops_reg;
    logic [LANES-1:0] s1_en_reg;
    logic             s1_adv;
    logic             s1_load;

    logic             s2_valid_reg;
    instClassType     class_reg [LANES];
    logic [LANES-1:0] lane_en_reg;
    logic [LANES-1:0] illegal_reg;
    decode_res_t      dec [LANES];

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       ill_pop;
    logic [CNT_W+3:0] cnt_sum;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign in_ops[gi*OP_W +: OP_W] = in_inst[gi*INST_W +: OP_W];
            assign dec[gi] = decode_inst(s1_ops_reg[gi*OP_W +: OP_W], s1_en_reg[gi]);
        end
    endgenerate

    assign s1_adv   = ~s2_valid_reg | out_ready;
    assign s1_load  = ~s1_valid_reg | s1_adv;
    assign up_ready = s1_load;

    generate
        if (SKID != 0) begin : g_skid
            gm_skid_buf #(
                .WIDTH(BW)
            ) u_skid (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid),
                .in_ready (in_ready),
                .in_data  ({in_lane_en, in_ops}),
                .out_valid(up_valid),
                .out_ready(up_ready),
                .out_data (up_data)
            );
        end else begin : g_direct
            assign up_valid = in_valid;
            assign in_ready = up_ready;
            assign up_data  = {in_lane_en, in_ops};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_ops_reg   <= '0;
            s1_en_reg    <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= up_valid;
            if (up_valid) begin
                {s1_en_reg, s1_ops_reg} <= up_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            lane_en_reg  <= '0;
            illegal_reg  <= '0;
            for (int i = 0; i < LANES; i++) begin
                class_reg[i] <= '0;
            end
        end else if (s1_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                lane_en_reg <= s1_en_reg;
                for (int i = 0; i < LANES; i++) begin
                    class_reg[i]   <= dec[i].cls;
                    illegal_reg[i] <= dec[i].illegal;
                end
            end
        end
    end

    always_comb begin
        ill_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            ill_pop = ill_pop + 4'(illegal_reg[i]);
        end
        cnt_sum  = {4'b0, cnt_reg} + {{CNT_W{1'b0}}, ill_pop};
        cnt_next = (cnt_sum > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (s2_valid_reg && out_ready) begin
            cnt_reg <= cnt_next;
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_class   = class_reg;
    assign out_lane_en = lane_en_reg;
    assign out_illegal = illegal_reg;
    assign illegal_cnt = cnt_reg;

    // Upstream must hold a refused bundle unchanged until it is taken.
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_inst)));

endmodule

// File: tb/tb_gm_inst_decode_pipe.sv
// Bench for gm_inst_decode_pipe: a SKID=1/CNT_W=16 instance and a SKID=0/CNT_W=4
// instance, selected one at a time, checked by a vector table and a scoreboard.
module tb_gm_inst_decode_pipe;
    import gmcupkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        c_in_valid;
    logic [63:0] c_in_inst;
    logic [1:0]  c_in_lane_en;
    logic        c_out_ready;

    logic         a_in_valid, a_in_ready, a_out_valid;
    instClassType a_out_class [2];
    logic [1:0]   a_out_lane_en, a_out_illegal;
    logic [15:0]  a_cnt;

    logic         b_in_valid, b_in_ready, b_out_valid;
    instClassType b_out_class [2];
    logic [1:0]   b_out_lane_en, b_out_illegal;
    logic [3:0]   b_cnt;

    logic                c_in_ready, c_out_valid;
    instClassType [1:0]  c_out_class;
    logic [1:0]          c_out_lane_en, c_out_illegal;
    logic [15:0]         c_cnt;

    assign a_in_valid = c_in_valid & ~sel;
    assign b_in_valid = c_in_valid & sel;

    always_comb begin
        c_in_ready    = sel ? b_in_ready    : a_in_ready;
        c_out_valid   = sel ? b_out_valid   : a_out_valid;
        c_out_lane_en = sel ? b_out_lane_en : a_out_lane_en;
        c_out_illegal = sel ? b_out_illegal : a_out_illegal;
        c_cnt         = sel ? {12'b0, b_cnt} : a_cnt;
        for (int i = 0; i < 2; i++) begin
            c_out_class[i] = sel ? b_out_class[i] : a_out_class[i];
        end
    end

    gm_inst_decode_pipe #(.LANES(2), .INST_W(32), .CNT_W(16), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_inst(c_in_inst), .in_lane_en(c_in_lane_en), .out_valid(a_out_valid),
        .out_ready(c_out_ready), .out_class(a_out_class), .out_lane_en(a_out_lane_en),
        .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
    );

    gm_inst_decode_pipe #(.LANES(2), .INST_W(32), .CNT_W(4), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_inst(c_in_inst), .in_lane_en(c_in_lane_en), .out_valid(b_out_valid),
        .out_ready(c_out_ready), .out_class(b_out_class), .out_lane_en(b_out_lane_en),
        .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
    );

    typedef struct packed {
        instClassType [1:0] cls;
        logic [1:0]         en;
        logic [1:0]         ill;
    } exp_t;

    typedef struct {
        logic [31:0]  i0;
        logic [31:0]  i1;
        logic [1:0]   en;
        instClassType c0;
        instClassType c1;
        logic [1:0]   ill;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   model_cnt = 0;
    int   cnt_max = 65535;
    exp_t exp_q[$];
    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic instClassType mk(input logic b, input iFuncType f,
                                        input logic s, input logic s3);
        instClassType c;
        c = '0;
        c.isBool = b;
        c.iFunc = f;
        c.sub.bool = s;
        c.sub2.sub3.bool = s3;
        return c;
    endfunction

    function automatic void model_lane(input logic [5:0] op, input logic en,
                                       output instClassType c, output logic ill);
        c = '0;
        ill = 1'b0;
        if (en) begin
            case (op)
                6'h00: ;
                6'h01: c = mk(1'b0, IFUNC_ADD, 1'b0, 1'b0);
                6'h21: c = mk(1'b1, IFUNC_BOOL, 1'b1, 1'b0);
                6'h22: c = mk(1'b1, IFUNC_BOOL, 1'b0, 1'b1);
                default: ill = 1'b1;
            endcase
        end
    endfunction

    function automatic exp_t model_bundle(input logic [63:0] inst, input logic [1:0] en);
        exp_t e;
        instClassType c;
        logic il;
        e = '0;
        e.en = en;
        for (int i = 0; i < 2; i++) begin
            model_lane(inst[i*32 +: 6], en[i], c, il);
            e.cls[i] = c;
            e.ill[i] = il;
        end
        return e;
    endfunction

    task automatic sat_add(input int n);
        model_cnt = (model_cnt + n > cnt_max) ? cnt_max : model_cnt + n;
    endtask

    function automatic logic [31:0] gen_inst(input int mode);
        logic [31:0] w;
        w = $urandom;
        if (mode == 2) begin
            w[5:0] = {2'b11, w[3:0]};
        end else begin
            case ($urandom_range(0, 4))
                0: w[5:0] = 6'h00;
                1: w[5:0] = 6'h01;
                2: w[5:0] = 6'h21;
                3: w[5:0] = 6'h22;
                default: ;
            endcase
        end
        return w;
    endfunction

    // One bundle through an otherwise idle pipe with out_ready held high.
    task automatic apply_vec(input int k);
        c_out_ready  = 1'b1;
        c_in_valid   = 1'b1;
        c_in_inst    = {vt[k].i1, vt[k].i0};
        c_in_lane_en = vt[k].en;
        @(negedge clk);
        chk($sformatf("vec%0d in_ready", k), 64'(c_in_ready), 64'(1));
        tick;
        c_in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d out_valid_c1", k), 64'(c_out_valid), 64'(0));
        tick;
        @(negedge clk);
        chk($sformatf("vec%0d out_valid_c2", k), 64'(c_out_valid), 64'(1));
        chk($sformatf("vec%0d class", k), 64'(c_out_class), 64'({vt[k].c1, vt[k].c0}));
        chk($sformatf("vec%0d lane_en", k), 64'(c_out_lane_en), 64'(vt[k].en));
        chk($sformatf("vec%0d illegal", k), 64'(c_out_illegal), 64'(vt[k].ill));
        sat_add($countones(vt[k].ill));
        tick;
        @(negedge clk);
        chk($sformatf("vec%0d illegal_cnt", k), 64'(c_cnt), 64'(model_cnt));
        tick;
    endtask

    // mode 0: out_ready low on cycles 5-9; 1: random valid/ready; 2: all-illegal, ready high.
    task automatic run_stream(input int n, input int mode);
        int          sent = 0;
        int          recv = 0;
        int          cyc = 0;
        logic        have = 1'b0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_out = '0;
        exp_t        e;
        while (recv < n && cyc < 3000) begin
            if (!have && sent < n && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                c_in_inst    = {gen_inst(mode), gen_inst(mode)};
                c_in_lane_en = (mode == 2) ? 2'b11 : 2'($urandom_range(0, 3));
                have = 1'b1;
            end
            c_in_valid = have;
            if (mode == 0)      c_out_ready = !(cyc >= 5 && cyc <= 9);
            else if (mode == 1) c_out_ready = ($urandom_range(0, 2) != 0);
            else                c_out_ready = 1'b1;
            @(negedge clk);
            chk("stream illegal_cnt", 64'(c_cnt), 64'(model_cnt));
            if (prev_stall) begin
                chk("stall hold", 64'({c_out_valid, c_out_class, c_out_lane_en, c_out_illegal}),
                    64'({1'b1, prev_out}));
            end
            if (mode == 0 && cyc == 5) chk("skid in_ready at stall", 64'(c_in_ready), 64'(1));
            if (mode == 0 && cyc == 6) chk("skid in_ready after stall", 64'(c_in_ready), 64'(0));
            if (c_out_valid && c_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected output", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bundle %0d", recv),
                        64'({c_out_class, c_out_lane_en, c_out_illegal}), 64'(e));
                    sat_add($countones(e.ill));
                end
                recv++;
            end
            prev_stall = c_out_valid && !c_out_ready;
            prev_out   = {c_out_class, c_out_lane_en, c_out_illegal};
            if (c_in_valid && c_in_ready) begin
                exp_q.push_back(model_bundle(c_in_inst, c_in_lane_en));
                have = 1'b0;
                sent++;
            end
            tick;
            cyc++;
        end
        chk("stream received all", 64'(recv), 64'(n));
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        @(negedge clk);
        chk("stream final illegal_cnt", 64'(c_cnt), 64'(model_cnt));
        tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h0000_0021, 32'h0000_0001, 2'b11,
                  mk(1, IFUNC_BOOL, 1, 0), mk(0, IFUNC_ADD, 0, 0), 2'b00};
        vt[1] = '{32'h0000_003F, 32'h0000_0022, 2'b01, '0, '0, 2'b01};
        vt[2] = '{32'h0000_0022, 32'h0000_0000, 2'b11,
                  mk(1, IFUNC_BOOL, 0, 1), '0, 2'b00};
        vt[3] = '{32'hFFFF_FFC1, 32'hABCD_0040, 2'b11,
                  mk(0, IFUNC_ADD, 0, 0), '0, 2'b00};
        vt[4] = '{32'h0000_0010, 32'h1234_567F, 2'b11, '0, '0, 2'b11};
        vt[5] = '{32'h0000_0021, 32'h0000_002A, 2'b10, '0, '0, 2'b10};
        vt[6] = '{32'h0000_0002, 32'h0000_0021, 2'b00, '0, '0, 2'b00};

        rst = 1'b1;
        sel = 1'b0;
        c_in_valid = 1'b0;
        c_in_inst = '0;
        c_in_lane_en = '0;
        c_out_ready = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        @(negedge clk);
        chk("reset a in_ready", 64'(a_in_ready), 64'(1));
        chk("reset a out_valid", 64'(a_out_valid), 64'(0));
        chk("reset a outputs", 64'({a_out_class[1], a_out_class[0], a_out_lane_en, a_out_illegal}), 64'(0));
        chk("reset a illegal_cnt", 64'(a_cnt), 64'(0));
        chk("reset b in_ready", 64'(b_in_ready), 64'(1));
        chk("reset b out_valid", 64'(b_out_valid), 64'(0));
        chk("reset b illegal_cnt", 64'(b_cnt), 64'(0));
        tick;

        for (int k = 0; k < 7; k++) begin
            apply_vec(k);
        end

        run_stream(20, 0);

        // Both stages full and stalled, then reset.
        c_out_ready  = 1'b0;
        c_in_valid   = 1'b1;
        c_in_inst    = {32'h0000_0001, 32'h0000_003F};
        c_in_lane_en = 2'b11;
        @(negedge clk);
        chk("rst test accept0", 64'(c_in_ready), 64'(1));
        tick;
        c_in_inst = {32'h0000_0022, 32'h0000_0021};
        @(negedge clk);
        chk("rst test accept1", 64'(c_in_ready), 64'(1));
        tick;
        c_in_valid = 1'b0;
        @(negedge clk);
        chk("rst test full out_valid", 64'(c_out_valid), 64'(1));
        tick;
        rst = 1'b1;
        @(negedge clk);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst out_valid", 64'(c_out_valid), 64'(0));
        chk("post-rst illegal_cnt", 64'(c_cnt), 64'(0));
        chk("post-rst out_illegal", 64'(c_out_illegal), 64'(0));
        chk("post-rst in_ready", 64'(c_in_ready), 64'(1));
        model_cnt = 0;
        exp_q.delete();
        tick;
        apply_vec(0);
        @(negedge clk);
        chk("post-rst no ghost output", 64'(c_out_valid), 64'(0));
        tick;

        run_stream(150, 1);

        sel = 1'b1;
        model_cnt = 0;
        cnt_max = 15;
        tick;
        run_stream(10, 2);
        chk("cnt saturated at 15", 64'(c_cnt), 64'(15));
        run_stream(100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
